// File: rtl/picomips_io_core.sv
// picomips_io_core: parametrised single-issue picoMIPS core with IN/OUT
// ports, BEQ, optional Q1.(N-1) multiply (macro PICOMIPS_MUL_EN) and HALT.
// Ports:
//   clk, reset             - clock, async active-high reset
//   imem_addr / imem_data  - program ROM address (PC) and instruction
//   in_data/in_valid/in_ready - input operand handshake for IN
//   out_data/out_valid     - registered OUT value and one-cycle pulse
//   halted                 - core has executed HALT
module picomips_io_core #(
    parameter int N     = 8,
    parameter int PSIZE = 5,
    parameter int RBITS = 3,
    parameter int ISIZE = 3 + 2 * RBITS + N
) (
    input  logic             clk,
    input  logic             reset,
    output logic [PSIZE-1:0] imem_addr,
    input  logic [ISIZE-1:0] imem_data,
    input  logic [N-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     out_data,
    output logic             out_valid,
    output logic             halted
);

    localparam int NREG = 1 << RBITS;

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [PSIZE-1:0] pc;
    logic [PSIZE-1:0] pc_next;
    logic [N-1:0]     regs [NREG];

    logic [2:0]       op;
    logic [RBITS-1:0] rd;
    logic [RBITS-1:0] rs;
    logic [N-1:0]     imm;
    logic [N-1:0]     rd_val;
    logic [N-1:0]     rs_val;

    logic             wr_en;
    logic [N-1:0]     wr_val;
    logic             do_out;

    logic op_nop, op_add, op_addi, op_sub;
    logic op_mul, op_beq, op_in, op_io;

    assign op  = imem_data[ISIZE-1 -: 3];
    assign rd  = imem_data[ISIZE-4 -: RBITS];
    assign rs  = imem_data[ISIZE-4-RBITS -: RBITS];
    assign imm = imem_data[N-1:0];

    // r0 is hard-wired to zero on the read side
    assign rd_val = (rd == '0) ? '0 : regs[rd];
    assign rs_val = (rs == '0) ? '0 : regs[rs];

    assign op_nop  = (op == 3'b000);
    assign op_add  = (op == 3'b001);
    assign op_addi = (op == 3'b010);
    assign op_sub  = (op == 3'b011);
    assign op_mul  = (op == 3'b100);
    assign op_beq  = (op == 3'b101);
    assign op_in   = (op == 3'b110);
    assign op_io   = (op == 3'b111);

`ifdef PICOMIPS_MUL_EN
    logic signed [2*N-1:0] prod;
    assign prod = $signed(rd_val) * $signed(rs_val);
`endif

    always_comb begin
        wr_en      = 1'b0;
        wr_val     = rd_val;
        pc_next    = pc + PSIZE'(1);
        state_next = state;
        do_out     = 1'b0;
        if (state == S_HALT) begin
            pc_next = pc;
        end else begin
            state_next = S_RUN;
            unique case (1'b1)
                op_nop: begin
                end
                op_add: begin
                    wr_en  = 1'b1;
                    wr_val = rd_val + rs_val;
                end
                op_addi: begin
                    wr_en  = 1'b1;
                    wr_val = rd_val + imm;
                end
                op_sub: begin
                    wr_en  = 1'b1;
                    wr_val = rd_val - rs_val;
                end
                op_mul: begin
`ifdef PICOMIPS_MUL_EN
                    // keep the Q1.(N-1) window of the product
                    wr_en  = 1'b1;
                    wr_val = N'(prod >>> (N - 1));
`endif
                end
                op_beq: begin
                    if (rd_val == rs_val)
                        pc_next = imm[PSIZE-1:0];
                end
                op_in: begin
                    if (in_valid) begin
                        wr_en  = 1'b1;
                        wr_val = in_data;
                    end else begin
                        pc_next    = pc;
                        state_next = S_WAIT;
                    end
                end
                op_io: begin
                    if (imm[0]) begin
                        pc_next    = pc;
                        state_next = S_HALT;
                    end else begin
                        do_out = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= '0;
            state     <= S_RUN;
            out_data  <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else begin
            pc        <= pc_next;
            state     <= state_next;
            out_valid <= do_out;
            if (do_out)
                out_data <= rd_val;
            if (wr_en && (rd != '0))
                regs[rd] <= wr_val;
        end
    end

    assign imem_addr = pc;
    assign halted    = (state == S_HALT);
    // gated by reset so the port is quiet while the core is held
    assign in_ready  = !reset && (state != S_HALT) && op_in;

endmodule

// File: tb/tb_picomips_io_core.sv
// tb_picomips_io_core: scoreboard bench for picomips_io_core; an
// instruction-level model predicts OUT values and the PC sequence.
module tb_picomips_io_core;

    localparam int N     = 8;
    localparam int PSIZE = 5;
    localparam int RBITS = 3;
    localparam int ISIZE = 3 + 2 * RBITS + N;
    localparam int DEPTH = 1 << PSIZE;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [PSIZE-1:0] imem_addr;
    logic [ISIZE-1:0] imem_data;
    logic [N-1:0]     in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     out_data;
    logic             out_valid;
    logic             halted;

    logic [ISIZE-1:0] rom [DEPTH];

    int        checks = 0;
    int        failures = 0;
    logic [7:0] out_q[$];
    int        pc_q[$];
    logic [7:0] in_vals[$];
    int        in_idx = 0;
    bit        auto_in = 1'b1;
    bit        mon_en = 1'b0;
    bit        xfer;
    int        halt_pc = 0;

    picomips_io_core #(
        .N(N), .PSIZE(PSIZE), .RBITS(RBITS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .halted(halted)
    );

    assign imem_data = rom[imem_addr];

    always #5 clk = ~clk;

    function automatic logic [ISIZE-1:0] enc(int op, int rd, int rs,
                                             int imm);
        logic [ISIZE-1:0] w;
        w = {op[2:0], rd[2:0], rs[2:0], imm[7:0]};
        return w;
    endfunction

    function automatic int op_of(int a);
        logic [ISIZE-1:0] w;
        w = rom[a];
        return int'(w[ISIZE-1 -: 3]);
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Instruction-level reference: walks the ROM, records every PC
    // executed and every value OUT should emit.
    task automatic run_model();
        int        m[8];
        int        pc;
        int        ii;
        int        op, rd, rs, imm, a, b, p;
        logic [ISIZE-1:0] w;
        bit        done;
        for (int i = 0; i < 8; i++) m[i] = 0;
        pc = 0;
        ii = 0;
        done = 1'b0;
        for (int step = 0; step < 5000 && !done; step++) begin
            w   = rom[pc];
            op  = int'(w[ISIZE-1 -: 3]);
            rd  = int'(w[ISIZE-4 -: 3]);
            rs  = int'(w[ISIZE-7 -: 3]);
            imm = int'(w[7:0]);
            a   = m[rd];
            b   = m[rs];
            pc_q.push_back(pc);
            case (op)
                1: if (rd != 0) m[rd] = (a + b) % 256;
                2: if (rd != 0) m[rd] = (a + imm) % 256;
                3: if (rd != 0) m[rd] = (a - b + 256) % 256;
                4: begin
`ifdef PICOMIPS_MUL_EN
                    if (a > 127) a = a - 256;
                    if (b > 127) b = b - 256;
                    p = (a * b) >>> 7;
                    if (rd != 0) m[rd] = p & 255;
`else
                    p = 0;
`endif
                end
                6: begin
                    if (rd != 0) m[rd] = int'(in_vals[ii]);
                    ii++;
                end
                7: begin
                    if (imm % 2 == 1) begin
                        done = 1'b1;
                        halt_pc = pc;
                    end else begin
                        out_q.push_back(8'(a));
                    end
                end
                default: ;
            endcase
            if (!done) begin
                if (op == 5 && a == b) pc = imm % DEPTH;
                else pc = (pc + 1) % DEPTH;
            end
        end
        if (!done) begin
            failures++;
            $display("FAIL model_halt: got 0 expected 1");
        end
    endtask

    // Input driver: presents in_vals in order with random gaps.
    initial begin
        forever begin
            @(negedge clk);
            xfer = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (auto_in) begin
                if (xfer) in_idx++;
                in_valid = ($urandom_range(0, 2) != 0);
                if (in_idx < in_vals.size())
                    in_data = in_vals[in_idx];
                else
                    in_data = 8'($urandom);
            end
        end
    end

    // Monitor: pops the scoreboards whenever the DUT shows an output.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid) begin
                checks++;
                if (out_q.size() == 0) begin
                    failures++;
                    $display("FAIL out_extra: got %0d expected none",
                             out_data);
                end else if (out_data !== out_q[0]) begin
                    failures++;
                    $display("FAIL out_data: got %0d expected %0d",
                             out_data, out_q[0]);
                    void'(out_q.pop_front());
                end else begin
                    void'(out_q.pop_front());
                end
            end
            if (pc_q.size() > 0) begin
                checks++;
                if (int'(imem_addr) != pc_q[0]) begin
                    failures++;
                    $display("FAIL pc: got %0d expected %0d",
                             imem_addr, pc_q[0]);
                end
                checks++;
                if (in_ready !== (op_of(pc_q[0]) == 6)) begin
                    failures++;
                    $display("FAIL in_ready: got %0d expected %0d",
                             in_ready, op_of(pc_q[0]) == 6);
                end
                if (pc_q.size() > 1 &&
                    !(op_of(pc_q[0]) == 6 && !in_valid))
                    void'(pc_q.pop_front());
            end
        end
    end

    task automatic fill_rom(logic [ISIZE-1:0] w);
        for (int i = 0; i < DEPTH; i++) rom[i] = w;
    endtask

    task automatic start_prog();
        mon_en = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_async_halted", int'(halted), 0);
        chk("rst_async_pc", int'(imem_addr), 0);
        chk("rst_async_oval", int'(out_valid), 0);
        chk("rst_async_odata", int'(out_data), 0);
        out_q.delete();
        pc_q.delete();
        in_idx = 0;
        run_model();
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;
        #1;
        chk("rel_pc", int'(imem_addr), 0);
        chk("rel_odata", int'(out_data), 0);
        chk("rel_oval", int'(out_valid), 0);
        chk("rel_halted", int'(halted), 0);
    endtask

    task automatic finish_prog(string name);
        int c;
        c = 0;
        while (!halted && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk({name, "_halted"}, int'(halted), 1);
        repeat (10) begin
            @(negedge clk);
            chk({name, "_hold_halted"}, int'(halted), 1);
            chk({name, "_hold_pc"}, int'(imem_addr), halt_pc);
            chk({name, "_hold_oval"}, int'(out_valid), 0);
        end
        chk({name, "_outs_left"}, out_q.size(), 0);
        chk({name, "_pcs_left"}, pc_q.size(), 1);
        mon_en = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int op;
        int imm;

        // every register reads 0 after reset
        fill_rom(enc(7, 0, 0, 1));
        for (int i = 0; i < 8; i++) rom[i] = enc(7, i, 0, 0);
        in_vals.delete();
        start_prog();
        finish_prog("reset_regs");

        // wrap-around add, r0 discard, 0-1 underflow, OUT then HALT
        fill_rom(enc(7, 0, 0, 1));
        rom[0] = enc(2, 1, 0, 200);
        rom[1] = enc(2, 2, 0, 100);
        rom[2] = enc(1, 1, 2, 0);
        rom[3] = enc(7, 1, 0, 0);
        rom[4] = enc(2, 5, 0, 1);
        rom[5] = enc(3, 0, 5, 0);
        rom[6] = enc(7, 0, 0, 0);
        rom[7] = enc(3, 4, 5, 0);
        rom[8] = enc(7, 4, 0, 0);
        rom[9] = enc(7, 0, 0, 1);
        start_prog();
        finish_prog("arith");

        // IN with a 5-cycle stall
        fill_rom(enc(7, 0, 0, 1));
        rom[0] = enc(6, 3, 0, 0);
        rom[1] = enc(7, 3, 0, 0);
        in_vals.delete();
        in_vals.push_back(8'h5A);
        auto_in = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        start_prog();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ready", int'(in_ready), 1);
            chk("stall_pc", int'(imem_addr), 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data = 8'h5A;
        @(negedge clk);
        chk("stall_ready_last", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("stall_pc_adv", int'(imem_addr), 1);
        finish_prog("stall");
        auto_in = 1'b1;

        // taken/untaken BEQ and PC wrap from 31 to 0
        fill_rom(enc(7, 0, 0, 1));
        rom[0]  = enc(5, 2, 0, 7);
        rom[1]  = enc(7, 2, 0, 0);
        rom[7]  = enc(2, 1, 0, 5);
        rom[8]  = enc(5, 1, 0, 20);
        rom[9]  = enc(7, 1, 0, 0);
        rom[10] = enc(2, 2, 0, 1);
        rom[11] = enc(5, 0, 0, 30);
        rom[30] = enc(7, 2, 0, 0);
        rom[31] = enc(0, 0, 0, 0);
        start_prog();
        finish_prog("beq_wrap");

        // fractional multiply (or NOP without the multiplier)
        fill_rom(enc(7, 0, 0, 1));
        rom[0] = enc(2, 1, 0, 8'h40);
        rom[1] = enc(2, 2, 0, 8'h40);
        rom[2] = enc(4, 1, 2, 0);
        rom[3] = enc(7, 1, 0, 0);
        rom[4] = enc(2, 3, 0, 8'hC0);
        rom[5] = enc(4, 3, 2, 0);
        rom[6] = enc(7, 3, 0, 0);
        start_prog();
        finish_prog("mul");

        // random straight-line programs with forward branches
        for (int t = 0; t < 20; t++) begin
            fill_rom(enc(7, 0, 0, 1));
            len = $urandom_range(8, DEPTH - 1);
            for (int i = 0; i < len - 1; i++) begin
                op  = $urandom_range(0, 7);
                imm = $urandom_range(0, 255);
                if (op == 5) imm = $urandom_range(i + 1, len - 1);
                if (op == 7)
                    imm = ($urandom_range(0, 9) == 0) ? 1 : 0;
                rom[i] = enc(op, $urandom_range(0, 7),
                             $urandom_range(0, 7), imm);
            end
            in_vals.delete();
            for (int i = 0; i < DEPTH; i++)
                in_vals.push_back(8'($urandom));
            start_prog();
            finish_prog("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/picomips_io_core.md
Name: picomips_io_core

Overview:
- Parametrised successor to the 8-bit picoMIPS datapath. Single-issue, one-instruction-per-cycle core.
- Configurable data width, program depth and register-file size.
- Adds conditional branching, a fixed-point multiply, a valid/ready input port, a registered output port and a halt state.
- Sits between an external combinational program ROM and board-level I/O (switches/LEDs).

Parameters:
- N, 8, data width in bits (>=4).
- PSIZE, 5, program-counter width; program depth is 2^PSIZE words.
- RBITS, 3, register-address width; register count is 2^RBITS.
- ISIZE, 3+2*RBITS+N, instruction width. Derived; must not be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  PSIZE  program address; equals the PC.
- imem_data  in  ISIZE  instruction at imem_addr, same-cycle combinational read.
- in_data  in  N  input operand.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  core is waiting on an IN instruction.
- out_data  out  N  last value written by OUT.
- out_valid  out  1  one-cycle pulse when out_data updates.
- halted  out  1  core has executed HALT.

Behaviour:
- Interface: one clock (clk). Reset (reset) is asynchronous and active-high.
- Encoding: opcode = [ISIZE-1:ISIZE-3]; Rd = next RBITS; Rs = next RBITS; imm = [N-1:0].
- Register r0 reads as 0; writes to r0 are discarded. All other registers reset to 0.
- Opcodes:
  - 000 NOP.
  - 001 ADD: Rd = Rd + Rs.
  - 010 ADDI: Rd = Rd + imm.
  - 011 SUB: Rd = Rd - Rs.
  - 100 MUL: signed Rd x Rs to a 2N-bit product; Rd = product[2N-2:N-1] (Q1.(N-1) fractional).
  - 101 BEQ: if Rd == Rs then PC = imm[PSIZE-1:0], else PC+1.
  - 110 IN: Rd = in_data.
  - 111 with imm[0]=0 is OUT (out_data = Rd); with imm[0]=1 is HALT.
- Arithmetic wraps modulo 2^N. No flags.
- FSM states: RUN, WAIT_IN, HALT.
  - RUN: execute the instruction at PC in one cycle. Register write and PC update occur on that cycle's rising edge.
  - RUN on IN: if in_valid=1 that cycle, complete immediately. Otherwise go to WAIT_IN; PC holds.
  - WAIT_IN: hold until in_valid=1. In that cycle, write Rd, increment PC, return to RUN.
  - HALT: entered on a HALT instruction. PC, registers and outputs freeze. Exit only by reset.
- in_ready:
  - Combinational: 1 when the state is not HALT and the current opcode is 110.
  - 0 during reset.
  - Transfer occurs when in_valid && in_ready at a rising edge.
- out_valid: high exactly one cycle after each OUT. out_data holds its value until the next OUT.
- PC wraps from 2^PSIZE-1 to 0. A BEQ target overrides the increment.
- Simultaneous events: an OUT immediately followed by HALT still produces its out_valid pulse.
- halted rises the cycle after HALT executes.
- Reset mid-operation (including in WAIT_IN or HALT) clears, asynchronously: PC=0, all registers=0, state=RUN, out_data=0, out_valid=0, halted=0.
- Latency: ALU/branch instructions take 1 cycle. IN takes 1 + the number of cycles waiting for in_valid.

Optional Feature:
- Macro: PICOMIPS_MUL_EN.
- Defined: opcode 100 performs MUL as specified.
- Undefined: no multiplier is synthesised; opcode 100 executes as NOP (PC+1, no register write).

Test Plan:
- Reset check:
  - Hold reset, then release.
  - Expect imem_addr=0, out_data=0, out_valid=0, halted=0.
  - r0..r7 are 0 (observed via OUT of each register).
- ADDI/ADD/SUB wrap (N=8):
  - Run ADDI r1,200; ADDI r2,100; ADD r1,r2; OUT r1.
  - Expect out_data=44 and a one-cycle out_valid.
  - Then SUB r0-based underflow, 0-1, gives 255.
- IN stall:
  - Issue IN r3 with in_valid low for 5 cycles, then in_data=0x5A with in_valid=1.
  - Expect in_ready=1 for 6 cycles and PC held.
  - Then r3=0x5A and PC advances by 1.
- BEQ and wrap:
  - BEQ r0,r0,7 jumps to 7; BEQ with unequal operands goes to PC+1.
  - With PSIZE=5, executing NOPs from address 31 gives imem_addr=0 next cycle.
- MUL, with PICOMIPS_MUL_EN defined:
  - 0x40 x 0x40 (0.5 x 0.5) gives 0x20.
  - 0xC0 x 0x40 (-0.5 x 0.5) gives 0xE0.
  - With the macro undefined, Rd is unchanged.
- HALT and reset:
  - OUT r1 followed by HALT: out_valid pulse, halted=1, imem_addr frozen for 10 cycles.
  - Assert reset mid-cycle: halted drops without a clock edge; execution restarts at 0.
